// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle for sync_fifo_flex.
// master drives requests and data; slave is the FIFO.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_en, din, rd_en,
        input  dout, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, din, rd_en,
        output dout, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO: any depth, standard or FWFT read,
// programmable thresholds, flush and error pulses.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter bit FWFT       = 1'b0,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input logic             clk,
    input logic             rst_n,
    sync_fifo_flex_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("sync_fifo_flex: DEPTH out of range");
    end
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_lvl
        $error("sync_fifo_flex: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);
    assign wr_acc = bus.wr_en & ~full & ~bus.flush;
    assign rd_acc = bus.rd_en & ~empty & ~bus.flush;

    // Wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(
        input logic [ADDR_WIDTH-1:0] p
    );
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            overflow_q  <= bus.wr_en & full;
            underflow_q <= bus.rd_en & empty;
        end
    end

    // Storage is not reset; rst_n gating blocks a write racing reset.
    always_ff @(posedge clk) begin
        if (wr_acc && rst_n) mem[wr_ptr] <= bus.din;
    end

    if (FWFT) begin : g_fwft
        assign bus.dout = mem[rd_ptr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)         dout_q <= '0;
            else if (bus.flush) dout_q <= '0;
            else if (rd_acc)    dout_q <= mem[rd_ptr];
        end
        assign bus.dout = dout_q;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CNT_AF);
    assign bus.almost_empty = (count_q <= CNT_AE);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
